// File: rtl/lcs_uart_tx_if.sv
// lcs_uart_tx_if: request/data/serial-line bundle between the answer stage
// (master) and the serial transmitter (slave).
interface lcs_uart_tx_if;
   logic       req;
   logic [7:0] dataTx;
   logic       tx;
   logic       busy;
   logic       done;
   logic       overrun;

   modport master (output req, dataTx, input tx, busy, done, overrun);
   modport slave  (input req, dataTx, output tx, busy, done, overrun);
endinterface

// File: rtl/lcs_uart_tx.sv
// lcs_uart_tx: asynchronous serial byte transmitter (start, 8 data LSB first,
// optional even parity, STOP_BITS stop bits). A request is the rising edge of
// the synchronised req level; requests during a frame are dropped and flagged.
// Optional feature macro: LCS_UART_PARITY_EN inserts an even parity bit.
module lcs_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input logic          clk,
   input logic          rst,
   lcs_uart_tx_if.slave bus
);

   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef LCS_UART_PARITY_EN
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`else
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

   state_t          state_q, state_d;
   logic [2:0]      sync_rq_q;
   logic [CW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            overrun_q, overrun_d;
`ifdef LCS_UART_PARITY_EN
   logic            parity_q, parity_d;
`endif

   logic            rise_s;
   logic            wrap_s;

   assign rise_s = sync_rq_q[1] & ~sync_rq_q[2];
   assign wrap_s = (baud_q == BAUD_LAST);

   // Next-state and output logic for the frame sequencer.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      overrun_d = 1'b0;
`ifdef LCS_UART_PARITY_EN
      parity_d  = parity_q;
`endif
      if (state_q == IDLE) begin
         tx_d   = 1'b1;
         busy_d = 1'b0;
         baud_d = {CW{1'b0}};
         bit_d  = 3'd0;
         if (rise_s) begin
            shreg_d  = bus.dataTx;
`ifdef LCS_UART_PARITY_EN
            parity_d = even_parity(bus.dataTx);
`endif
            state_d  = START;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
         end else begin
            state_d  = IDLE;
         end
      end else begin
         // Frame in progress: a new edge is dropped, only flagged.
         overrun_d = rise_s;
         if (wrap_s) begin
            baud_d = {CW{1'b0}};
         end else begin
            baud_d = baud_q + {{(CW-1){1'b0}}, 1'b1};
         end
         case (state_q)
            START: begin
               if (wrap_s) begin
                  state_d = DATA;
                  tx_d    = shreg_q[0];
               end else begin
                  state_d = START;
               end
            end
            DATA: begin
               if (wrap_s) begin
                  shreg_d = {1'b0, shreg_q[7:1]};
                  if (bit_q == 3'd7) begin
                     bit_d   = 3'd0;
`ifdef LCS_UART_PARITY_EN
                     state_d = PARITY;
                     tx_d    = parity_q;
`else
                     state_d = STOP;
                     tx_d    = 1'b1;
`endif
                  end else begin
                     bit_d = bit_q + 3'd1;
                     tx_d  = shreg_q[1];
                  end
               end else begin
                  state_d = DATA;
               end
            end
`ifdef LCS_UART_PARITY_EN
            PARITY: begin
               if (wrap_s) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
                  bit_d   = 3'd0;
               end else begin
                  state_d = PARITY;
               end
            end
`endif
            STOP: begin
               tx_d = 1'b1;
               if (wrap_s) begin
                  if (bit_q == STOP_LAST) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     bit_d   = 3'd0;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  state_d = STOP;
               end
            end
            default: begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State, request synchroniser and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sync_rq_q <= 3'b000;
         baud_q    <= {CW{1'b0}};
         bit_q     <= 3'd0;
         shreg_q   <= 8'h00;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
`ifdef LCS_UART_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sync_rq_q <= {sync_rq_q[1:0], bus.req};
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
`ifdef LCS_UART_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign bus.tx      = tx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_lcs_uart_tx.sv
// tb_lcs_uart_tx: directed bench for lcs_uart_tx at CLKS_PER_BIT=4.
// A second instance with STOP_BITS=2 shares the request stimulus.
module tb_lcs_uart_tx;

   localparam int CPB = 4;
`ifdef LCS_UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int L = 10 + P;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_mis;

   logic tx_s    [128];
   logic busy_s  [128];
   logic done_s  [128];
   logic ovr_s   [128];
   logic tx2_s   [128];
   logic busy2_s [128];
   logic done2_s [128];

   lcs_uart_tx_if bus ();
   lcs_uart_tx_if bus2 ();

   assign bus2.req    = bus.req;
   assign bus2.dataTx = bus.dataTx;

   lcs_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (.clk(clk), .rst(rst), .bus(bus));
   lcs_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample every negedge for ncyc cycles; sample 0 follows the edge that first sees req.
   task automatic capture(input int ncyc, input int drop_at, input int rise_at, input int rst_at);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         tx_s[i]    = bus.tx;
         busy_s[i]  = bus.busy;
         done_s[i]  = bus.done;
         ovr_s[i]   = bus.overrun;
         tx2_s[i]   = bus2.tx;
         busy2_s[i] = bus2.busy;
         done2_s[i] = bus2.done;
         if (i == 3) bus.dataTx = ~bus.dataTx;
         if (i == drop_at) bus.req = 1'b0;
         if (i == rise_at) bus.req = 1'b1;
         rst = (i == rst_at);
      end
   endtask

   task automatic check_frame(input string nm, input logic [7:0] d, input int ncyc,
                              input int exp_ovr, input bit chk2);
      logic [15:0] fr;
      logic [3:0]  nib;
      logic [7:0]  stop2;
      int busy_n, first_busy, done_n, done_i, ovr_n, tail_low, busy2_n, done2_i;
      fr = 16'h0000;
      fr[0] = 1'b0;
      for (int j = 0; j < 8; j++) fr[1+j] = d[j];
`ifdef LCS_UART_PARITY_EN
      fr[9] = ^d;
`endif
      fr[9+P] = 1'b1;
      chk($sformatf("%s_pre", nm), 32'(tx_s[1]), 32'd1);
      for (int b = 0; b < L; b++) begin
         nib = {tx_s[2+CPB*b+3], tx_s[2+CPB*b+2], tx_s[2+CPB*b+1], tx_s[2+CPB*b]};
         chk($sformatf("%s_bit%0d", nm, b), 32'(nib), 32'({4{fr[b]}}));
      end
      busy_n = 0; first_busy = -1; done_n = 0; done_i = -1; ovr_n = 0; tail_low = 0;
      busy2_n = 0; done2_i = -1;
      for (int i = 0; i < ncyc; i++) begin
         busy_n += int'(busy_s[i]);
         if (busy_s[i] && first_busy < 0) first_busy = i;
         if (done_s[i]) begin done_n++; done_i = i; end
         ovr_n += int'(ovr_s[i]);
         if (i >= 2 + CPB*L && !tx_s[i]) tail_low++;
         busy2_n += int'(busy2_s[i]);
         if (done2_s[i]) done2_i = i;
      end
      chk($sformatf("%s_busy_len", nm), 32'(busy_n), 32'(CPB*L));
      chk($sformatf("%s_busy_start", nm), 32'(first_busy), 32'd2);
      chk($sformatf("%s_done_cnt", nm), 32'(done_n), 32'd1);
      chk($sformatf("%s_done_at", nm), 32'(done_i), 32'(2 + CPB*L));
      chk($sformatf("%s_overrun", nm), 32'(ovr_n), 32'(exp_ovr));
      chk($sformatf("%s_tail_idle", nm), 32'(tail_low), 32'd0);
      if (chk2) begin
         for (int k = 0; k < 8; k++) stop2[k] = tx2_s[2 + CPB*(9+P) + k];
         chk($sformatf("%s_s2_busy_len", nm), 32'(busy2_n), 32'(CPB*(L+1)));
         chk($sformatf("%s_s2_done_at", nm), 32'(done2_i), 32'(2 + CPB*(L+1)));
         chk($sformatf("%s_s2_stop", nm), 32'(stop2), 32'hFF);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int bad_tx, bad_busy, bad_done;
      n_vec = 0;
      n_mis = 0;
      rst = 1'b1;
      bus.req = 1'b0;
      bus.dataTx = 8'h00;
      idle(3);
      chk("rst_tx", 32'(bus.tx), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;

      // Quiet line for 20 cycles
      bad_tx = 0; bad_busy = 0; bad_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!bus.tx) bad_tx++;
         if (bus.busy) bad_busy++;
         if (bus.done) bad_done++;
      end
      chk("quiet_tx", 32'(bad_tx), 32'd0);
      chk("quiet_busy", 32'(bad_busy), 32'd0);
      chk("quiet_done", 32'(bad_done), 32'd0);

      // Basic frame 8'hA5
      bus.dataTx = 8'hA5; bus.req = 1'b1;
      capture(64, 3, -1, -1);
      check_frame("a5", 8'hA5, 64, 0, 1'b1);

      // Second rising edge mid-frame is dropped and flagged
      idle(2);
      bus.dataTx = 8'h3C; bus.req = 1'b1;
      capture(64, 3, 8, -1);
      check_frame("ovr", 8'h3C, 64, 1, 1'b1);
      bus.req = 1'b0;
      idle(4);

      // Reset 15 cycles into an 8'h00 frame
      bus.dataTx = 8'h00; bus.req = 1'b1;
      capture(40, 3, -1, 15);
      chk("rst_mid_before", 32'(tx_s[14]), 32'd0);
      chk("rst_mid_tx", 32'(tx_s[16]), 32'd1);
      chk("rst_mid_busy", 32'(busy_s[16]), 32'd0);
      bad_tx = 0;
      for (int i = 16; i < 40; i++) if (!tx_s[i] || busy_s[i]) bad_tx++;
      chk("rst_mid_quiet", 32'(bad_tx), 32'd0);
      bus.dataTx = 8'hC3; bus.req = 1'b1;
      capture(64, 3, -1, -1);
      check_frame("post_rst", 8'hC3, 64, 0, 1'b1);
      idle(2);

      // Back-to-back: 8'h07 with req held high, low at done, rise 2 cycles later with 8'hFF
      bus.dataTx = 8'h07; bus.req = 1'b1;
      capture(2 + CPB*L + 1, 2 + CPB*L, -1, -1);
      check_frame("b2b_1", 8'h07, 2 + CPB*L + 1, 0, 1'b0);
      idle(1);
      @(negedge clk);
      bus.dataTx = 8'hFF; bus.req = 1'b1;
      capture(64, 3, -1, -1);
      check_frame("b2b_2", 8'hFF, 64, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
